// File: rtl/lpt_pkg.sv
// Shared constants, types and saturating-counter helpers for the local
// prediction table and its in-flight index queue.
package lpt_pkg;

    localparam int HIST_W    = 10;
    localparam int CTR_W     = 3;
    localparam int Q_DEPTH   = 4;
    localparam int TBL_DEPTH = 1 << HIST_W;
    localparam int PTR_W     = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W     = $clog2(Q_DEPTH + 1);

    typedef logic [CTR_W-1:0]  ctr_t;
    typedef logic [HIST_W-1:0] idx_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam ctr_t CTR_INIT = 3'b011;
    localparam ctr_t CTR_MAX  = {CTR_W{1'b1}};
    localparam ctr_t CTR_MIN  = {CTR_W{1'b0}};
    localparam ptr_t PTR_LAST = ptr_t'(Q_DEPTH - 1);
    localparam cnt_t CNT_FULL = cnt_t'(Q_DEPTH);
    localparam cnt_t CNT_ZERO = {CNT_W{1'b0}};

    function automatic ctr_t sat_inc(input ctr_t c);
        ctr_t r;
        if (c == CTR_MAX) begin
            r = c;
        end else begin
            r = c + ctr_t'(1);
        end
        return r;
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        ctr_t r;
        if (c == CTR_MIN) begin
            r = c;
        end else begin
            r = c - ctr_t'(1);
        end
        return r;
    endfunction

    // Pointer advance that also wraps correctly for non-power-of-two depths.
    function automatic ptr_t ptr_next(input ptr_t p);
        ptr_t r;
        if (p == PTR_LAST) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + ptr_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/lpt_index_fifo.sv
// In-order queue of table indices awaiting branch resolution.
// Full/empty are registered and come from the next-state occupancy.
module lpt_index_fifo
    import lpt_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [HIST_W-1:0] push_idx,
    output logic [HIST_W-1:0] head_idx,
    output logic              push_acc,
    output logic              pop_acc,
    output logic              full,
    output logic              empty
);

    idx_t mem_q [Q_DEPTH];
    idx_t mem_d [Q_DEPTH];
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic push_ok_s;
    logic pop_ok_s;

    // Push is gated by the current full flag, so a same-cycle pop never frees a slot.
    always_comb begin
        push_ok_s = push & ~full_q;
        pop_ok_s  = pop & ~empty_q;
        mem_d     = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_idx;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == CNT_ZERO);
    end

    // Queue state registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                mem_q[i] <= {HIST_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_ZERO;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head_idx = mem_q[rd_ptr_q];
    assign push_acc = push_ok_s;
    assign pop_acc  = pop_ok_s;
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/local_predict_table.sv
// Local-history indexed table of saturating counters with in-order training
// from resolved branches; same-index lookup during training sees the new value.
module local_predict_table
    import lpt_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              PredictReq,
    input  logic [HIST_W-1:0] LHindex,
    input  logic              Resolve,
    input  logic              BranchTaken,
    output logic              Prediction,
    output logic              PredictValid,
    output logic              QueueFull,
    output logic              QueueEmpty,
    output logic              ResolveError
);

    ctr_t table_q [TBL_DEPTH];

    idx_t head_idx_s;
    logic push_acc_s;
    logic pop_acc_s;
    logic full_s;
    logic empty_s;
    ctr_t cur_ctr_s;
    ctr_t upd_ctr_s;
    ctr_t lookup_ctr_s;

    logic prediction_q, prediction_d;
    logic pred_valid_q, pred_valid_d;
    logic resolve_err_q, resolve_err_d;

    lpt_index_fifo u_index_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (PredictReq),
        .pop      (Resolve),
        .push_idx (LHindex),
        .head_idx (head_idx_s),
        .push_acc (push_acc_s),
        .pop_acc  (pop_acc_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    // Training value for the head entry and write-first lookup bypass.
    always_comb begin
        cur_ctr_s = table_q[head_idx_s];
        if (BranchTaken) begin
            upd_ctr_s = sat_inc(cur_ctr_s);
        end else begin
            upd_ctr_s = sat_dec(cur_ctr_s);
        end
        if (pop_acc_s && (head_idx_s == LHindex)) begin
            lookup_ctr_s = upd_ctr_s;
        end else begin
            lookup_ctr_s = table_q[LHindex];
        end
        if (push_acc_s) begin
            prediction_d = lookup_ctr_s[CTR_W-1];
        end else begin
            prediction_d = 1'b0;
        end
        pred_valid_d  = push_acc_s;
        resolve_err_d = Resolve & empty_s;
    end

    // Counter table: bulk reinit on reset, one trained entry per resolve.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                table_q[i] <= CTR_INIT;
            end
        end else if (pop_acc_s) begin
            table_q[head_idx_s] <= upd_ctr_s;
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prediction_q  <= 1'b0;
            pred_valid_q  <= 1'b0;
            resolve_err_q <= 1'b0;
        end else begin
            prediction_q  <= prediction_d;
            pred_valid_q  <= pred_valid_d;
            resolve_err_q <= resolve_err_d;
        end
    end

    assign Prediction   = prediction_q;
    assign PredictValid = pred_valid_q;
    assign ResolveError = resolve_err_q;
    assign QueueFull    = full_s;
    assign QueueEmpty   = empty_s;

endmodule

// File: tb/tb_local_predict_table.sv
// Directed vector table plus randomized traffic against an abstract model
// (integer counters and an index queue) of the local prediction table.
module tb_local_predict_table;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       PredictReq = 1'b0;
    logic [9:0] LHindex = 10'h000;
    logic       Resolve = 1'b0;
    logic       BranchTaken = 1'b0;
    logic       Prediction, PredictValid, QueueFull, QueueEmpty, ResolveError;

    local_predict_table dut (
        .clock        (clock),
        .reset        (reset),
        .PredictReq   (PredictReq),
        .LHindex      (LHindex),
        .Resolve      (Resolve),
        .BranchTaken  (BranchTaken),
        .Prediction   (Prediction),
        .PredictValid (PredictValid),
        .QueueFull    (QueueFull),
        .QueueEmpty   (QueueEmpty),
        .ResolveError (ResolveError)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       req;
        logic [9:0] idx;
        logic       res;
        logic       tk;
        logic       v;
        logic       p;
        logic       f;
        logic       e;
        logic       err;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   ctr_m [1024];
    int   q_m [$];
    logic e_v, e_p, e_f, e_e, e_err;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag, input bit pred_always);
        chk({tag, ".PredictValid"}, PredictValid, e_v);
        if (e_v || pred_always) chk({tag, ".Prediction"}, Prediction, e_p);
        chk({tag, ".QueueFull"}, QueueFull, e_f);
        chk({tag, ".QueueEmpty"}, QueueEmpty, e_e);
        chk({tag, ".ResolveError"}, ResolveError, e_err);
    endtask

    task automatic model_reset();
        foreach (ctr_m[i]) ctr_m[i] = 3;
        q_m.delete();
        e_v = 1'b0; e_p = 1'b0; e_f = 1'b0; e_e = 1'b1; e_err = 1'b0;
    endtask

    task automatic do_reset(input int cycles, input string tag);
        reset = 1'b0;
        PredictReq = 1'b0;
        Resolve = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        check_model(tag, 1'b1);
    endtask

    // One clock of stimulus; the model applies resolve first, then the lookup.
    task automatic step(input logic req, input logic [9:0] idx, input logic res,
                        input logic tk, input string tag);
        int  sz;
        int  h;
        bit  acc;
        PredictReq = req;
        LHindex = idx;
        Resolve = res;
        BranchTaken = tk;
        sz = q_m.size();
        acc = req && (sz < 4);
        e_err = res && (sz == 0);
        if (res && sz > 0) begin
            h = q_m.pop_front();
            if (tk) ctr_m[h] = (ctr_m[h] == 7) ? 7 : ctr_m[h] + 1;
            else    ctr_m[h] = (ctr_m[h] == 0) ? 0 : ctr_m[h] - 1;
        end
        e_v = acc;
        e_p = 1'b0;
        if (acc) begin
            e_p = (ctr_m[idx] >= 4);
            q_m.push_back(int'(idx));
        end
        e_f = (q_m.size() == 4);
        e_e = (q_m.size() == 0);
        @(posedge clock);
        #1;
        check_model(tag, 1'b0);
        PredictReq = 1'b0;
        Resolve = 1'b0;
    endtask

    function automatic vec_t mk(input logic req, input logic [9:0] idx, input logic res,
                                input logic tk, input logic v, input logic p,
                                input logic f, input logic e, input logic err);
        vec_t r;
        r.req = req; r.idx = idx; r.res = res; r.tk = tk;
        r.v = v; r.p = p; r.f = f; r.e = e; r.err = err;
        return r;
    endfunction

    vec_t vecs [$];

    initial begin
        string tag;
        logic [9:0] ridx;

        // req idx res tk | valid pred full empty err
        vecs.push_back(mk(1'b1, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 10'h155, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(1'b1, 10'h155, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
            vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        vecs.push_back(mk(1'b1, 10'h155, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        // Counter at 7; eight not-taken trains with bypassed lookups 6,5,4,3,2,1,0,0.
        vecs.push_back(mk(1'b1, 10'h155, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 10'h155, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 10'h155, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b1, 10'h155, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 10'h155, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        // Fill the queue, then a rejected fifth lookup.
        vecs.push_back(mk(1'b1, 10'h001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 10'h002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 10'h003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 10'h004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 10'h005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        // Read back idx1..4 = 100,010,100,100 while training them down.
        vecs.push_back(mk(1'b1, 10'h001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 10'h002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 10'h003, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 10'h004, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        // Resolve on empty queue: one-cycle error pulse, idx1 still 011.
        vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 10'h001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        // Same-cycle lookup/resolve on 3FF at 011 with taken: bypassed 100.
        vecs.push_back(mk(1'b1, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

        model_reset();
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) do_reset(1, $sformatf("reset%0d", i));

        foreach (vecs[i]) begin
            tag = $sformatf("vec%0d", i);
            step(vecs[i].req, vecs[i].idx, vecs[i].res, vecs[i].tk, {tag, ".model"});
            chk({tag, ".PredictValid"}, PredictValid, vecs[i].v);
            if (vecs[i].v) chk({tag, ".Prediction"}, Prediction, vecs[i].p);
            chk({tag, ".QueueFull"}, QueueFull, vecs[i].f);
            chk({tag, ".QueueEmpty"}, QueueEmpty, vecs[i].e);
            chk({tag, ".ResolveError"}, ResolveError, vecs[i].err);
        end

        // Reset with three entries in flight after training 155 up to 101.
        do_reset(1, "mid.pre");
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 10'h155, 1'b0, 1'b0, "mid.train_req");
            step(1'b0, 10'h000, 1'b1, 1'b1, "mid.train_res");
        end
        step(1'b1, 10'h155, 1'b0, 1'b0, "mid.fill0");
        chk("mid.trained_pred", Prediction, 1'b1);
        step(1'b1, 10'h001, 1'b0, 1'b0, "mid.fill1");
        step(1'b1, 10'h002, 1'b0, 1'b0, "mid.fill2");
        do_reset(1, "mid.reset");
        chk("mid.QueueEmpty", QueueEmpty, 1'b1);
        chk("mid.PredictValid", PredictValid, 1'b0);
        step(1'b1, 10'h155, 1'b0, 1'b0, "mid.readback");
        chk("mid.readback_pred", Prediction, 1'b0);
        step(1'b0, 10'h000, 1'b1, 1'b0, "mid.drain");

        // Randomized traffic on a small index pool to force aliasing.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset(1, $sformatf("rnd%0d.reset", i));
            end else begin
                case ($urandom_range(0, 3))
                    0:       ridx = 10'h155;
                    1:       ridx = 10'h3FF;
                    default: ridx = 10'($urandom_range(0, 5));
                endcase
                step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, ridx,
                     ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                     1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
